// File: rtl/mul_tree_feeder_bf16.sv
// mul_tree_feeder_bf16
//   Producer side of the bf16 multiplier-tree operand interface. Collects
//   bf16 leaf operands over valid/ready and packs them 8 per batch into the
//   128-bit tree operand word. Unfilled slots are padded with PAD_VALUE, and
//   each batch is announced with a one-cycle strobe. The grouping mode is
//   held stable while batches are outstanding. Outstanding batches are
//   tracked using the tree's result strobe.
//   Optional: define MUL_FEED_PERF_CNT_EN to add the perf_batches/perf_pads
//   counters.
module mul_tree_feeder_bf16 #(
    parameter int unsigned MAX_INFLIGHT = 15,
    parameter logic [15:0] PAD_VALUE    = 16'h3F80,
    localparam int unsigned CW          = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    cfg_mode,
    input  logic [15:0]   s_in_data,
    input  logic          s_in_valid,
    input  logic          s_in_last,
    output logic          s_in_ready,
    output logic [127:0]  mul_ins,
    output logic          mul_stb,
    output logic [1:0]    mode,
    input  logic [3:0]    res_stb,
    output logic [CW-1:0] in_flight,
    output logic          err_underflow
`ifdef MUL_FEED_PERF_CNT_EN
    ,
    output logic [31:0]   perf_batches,
    output logic [31:0]   perf_pads
`endif
);

    typedef enum logic {
        ST_FILL,
        ST_DRAIN
    } state_t;

    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_INFLIGHT);

    state_t             state_q, state_d;
    logic [2:0]         slot_cnt_q, slot_cnt_d;
    logic [7:0][15:0]   slots_q, slots_d;
    logic [127:0]       mul_ins_q, mul_ins_d;
    logic               mul_stb_q, mul_stb_d;
    logic [1:0]         mode_q, mode_d;
    logic [1:0]         req_mode_q, req_mode_d;
    logic [CW-1:0]      in_flight_q, in_flight_d;
    logic               err_q, err_d;

    logic               ready_c;
    logic               accept_c;
    logic               close_c;
    logic               retire_c;
    logic               mode_req_c;

    // Only res_stb[0] is a per-batch completion; the other strobes are
    // informational for this producer.
    logic               unused_res_hi;
    assign unused_res_hi = ^res_stb[3:1];

    // Next-state: handshake, slot packing, batch issue, mode latch, and in-flight tracking
    always_comb begin
        state_d     = state_q;
        slot_cnt_d  = slot_cnt_q;
        slots_d     = slots_q;
        mul_ins_d   = mul_ins_q;
        mul_stb_d   = 1'b0;
        mode_d      = mode_q;
        req_mode_d  = req_mode_q;
        in_flight_d = in_flight_q;
        err_d       = err_q;
        ready_c     = 1'b0;

        retire_c   = res_stb[0];
        mode_req_c = s_in_valid && (slot_cnt_q == 3'd0) && (cfg_mode != mode_q);

        if (state_q == ST_FILL) begin
            if (mode_req_c) begin
                // A mode change takes effect immediately if nothing is in
                // flight; otherwise wait in DRAIN for the tree to empty.
                if (in_flight_q == '0) begin
                    mode_d = cfg_mode;
                end else begin
                    state_d    = ST_DRAIN;
                    req_mode_d = cfg_mode;
                end
            end else begin
                ready_c = (in_flight_q < MAX_CNT);
            end
        end

        accept_c = ready_c && s_in_valid;
        close_c  = accept_c && ((slot_cnt_q == 3'd7) || s_in_last);

        if (accept_c) begin
            slots_d[slot_cnt_q] = s_in_data;
            slot_cnt_d          = slot_cnt_q + 3'd1;
        end

        // The closing beat goes straight into the operand word so the issue
        // lands one cycle after it, leaving the slot buffer free for the next batch.
        if (close_c) begin
            slot_cnt_d = '0;
            mul_stb_d  = 1'b1;
            for (int unsigned k = 0; k < 8; k++) begin
                if (k < 32'(slot_cnt_q)) begin
                    mul_ins_d[16*k +: 16] = slots_q[k[2:0]];
                end else if (k == 32'(slot_cnt_q)) begin
                    mul_ins_d[16*k +: 16] = s_in_data;
                end else begin
                    mul_ins_d[16*k +: 16] = PAD_VALUE;
                end
            end
        end

        // Issue and retire in the same cycle cancel. A retire with nothing
        // outstanding is flagged and not counted.
        if (retire_c && (in_flight_q == '0)) begin
            err_d       = 1'b1;
            in_flight_d = in_flight_q + CW'(close_c);
        end else begin
            in_flight_d = in_flight_q + CW'(close_c) - CW'(retire_c);
        end

        // Mode and in_flight update on the same edge, so mode never changes
        // while a batch is visibly outstanding.
        if ((state_q == ST_DRAIN) && (in_flight_d == '0)) begin
            mode_d  = req_mode_q;
            state_d = ST_FILL;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_FILL;
            slot_cnt_q  <= '0;
            slots_q     <= '0;
            mul_ins_q   <= '0;
            mul_stb_q   <= 1'b0;
            mode_q      <= 2'b00;
            req_mode_q  <= 2'b00;
            in_flight_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_cnt_q  <= slot_cnt_d;
            slots_q     <= slots_d;
            mul_ins_q   <= mul_ins_d;
            mul_stb_q   <= mul_stb_d;
            mode_q      <= mode_d;
            req_mode_q  <= req_mode_d;
            in_flight_q <= in_flight_d;
            err_q       <= err_d;
        end
    end

    assign s_in_ready    = ready_c & ~rst;
    assign mul_ins       = mul_ins_q;
    assign mul_stb       = mul_stb_q;
    assign mode          = mode_q;
    assign in_flight     = in_flight_q;
    assign err_underflow = err_q;

`ifdef MUL_FEED_PERF_CNT_EN
    logic [31:0] perf_batches_q, perf_batches_d;
    logic [31:0] perf_pads_q, perf_pads_d;

    // Perf counters: issued batches and padded slots, wrapping at 2^32
    always_comb begin
        perf_batches_d = perf_batches_q;
        perf_pads_d    = perf_pads_q;
        if (close_c) begin
            perf_batches_d = perf_batches_q + 32'd1;
            perf_pads_d    = perf_pads_q + 32'(3'd7 - slot_cnt_q);
        end
    end

    // Perf counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_batches_q <= '0;
            perf_pads_q    <= '0;
        end else begin
            perf_batches_q <= perf_batches_d;
            perf_pads_q    <= perf_pads_d;
        end
    end

    assign perf_batches = perf_batches_q;
    assign perf_pads    = perf_pads_q;
`endif

endmodule

// File: doc/mul_tree_feeder_bf16.md
Name: mul_tree_feeder_bf16

Overview:
- Producer side of the bf16 multiplier-tree operand interface.
- Accepts a stream of bf16 leaf operands with valid/ready, packs 8 per batch into the 128-bit tree operand word, and pulses the operand strobe.
- Drives the tree's grouping mode and keeps it stable while results are in flight; tracks in-flight batches using the tree's registered result strobes.

Parameters:
- MAX_INFLIGHT, 15, maximum outstanding batches; the in-flight counter width is clog2(MAX_INFLIGHT+1).
- PAD_VALUE, 16'h3F80, bf16 value placed in unfilled slots (1.0, the multiplicative identity).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cfg_mode  in  2  requested grouping: 00 = 2-2-2-2, 01 = 4-4, 10 = 6-2, 11 = 8
- s_in_data  in  16  bf16 operand
- s_in_valid  in  1  operand valid
- s_in_last  in  1  final operand of the current batch (early close)
- s_in_ready  out  1  operand accepted when valid&ready
- mul_ins  out  128  packed operands to the tree
- mul_stb  out  1  one-cycle operand strobe to the tree
- mode  out  2  grouping mode to the tree
- res_stb  in  4  registered result strobes from the tree
- in_flight  out  clog2(MAX_INFLIGHT+1)  outstanding batch count
- err_underflow  out  1  sticky; set on a result with no batch outstanding

Behaviour:
- Reset values: mul_ins=0, mul_stb=0, mode=00, in_flight=0, err_underflow=0, s_in_ready=0 in the reset cycle, slot count=0, state=FILL.
- Packing: the k-th accepted beat of a batch (k=0..7) goes to mul_ins[16k+15:16k]. Pair n therefore occupies [32n+31:32n], with operand 2n in the low half. All 8 slots are used in every mode; mode only changes the grouping.
- State FILL:
  - s_in_ready = (in_flight < MAX_INFLIGHT) and no pending mode change.
  - An accepted beat writes its slot and increments the slot count.
- Batch close: an accepted beat with slot count==7, or with s_in_last=1, closes the batch.
  - The next cycle: mul_ins holds the batch, unfilled slots = PAD_VALUE, mul_stb=1 for exactly one cycle, slot count returns to 0, and in_flight increments.
  - Latency from closing beat to mul_stb is 1 cycle.
  - FILL continues without a bubble: a beat accepted in the strobe cycle becomes slot 0 of the next batch.
  - mul_ins holds its value until the next issue.
- s_in_last on slot 7 is the same as a normal close. s_in_last on slot 0 issues a batch of 1 operand plus 7 pads.
- Mode latch: cfg_mode is sampled only when slot count==0 and s_in_valid=1.
  - If cfg_mode==mode: accept normally.
  - If cfg_mode!=mode and in_flight==0: mode updates in that cycle, s_in_ready=0, and the beat is accepted the following cycle.
  - If cfg_mode!=mode and in_flight!=0: enter DRAIN.
- State DRAIN: s_in_ready=0. When in_flight reaches 0, mode takes the requested value and the state returns to FILL on the next cycle. mode never changes while in_flight!=0.
- Retire:
  - Each cycle with res_stb[0]==1 counts as one completion; res_stb[0] fires once per batch in all modes.
  - Issue and retire in the same cycle leave in_flight unchanged.
  - Retire with in_flight==0 leaves the counter at 0 and sets err_underflow.
- Full: when in_flight==MAX_INFLIGHT, s_in_ready=0, including mid-batch. Partial slots are held.
- Reset mid-batch discards partial slots and any pending strobe. Result strobes from the tree after reset are counted as underflow only if in_flight==0.

Optional Feature:
- Macro MUL_FEED_PERF_CNT_EN.
- Defined: adds outputs perf_batches[31:0] (issued batches) and perf_pads[31:0] (total padded slots). Both reset to 0, count up, and wrap at 2^32.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- mode=00, beats 0x0001..0x0008, no last -> 1 cycle after 8th beat: mul_stb=1 for 1 cycle, mul_ins=0x0008_0007_0006_0005_0004_0003_0002_0001, in_flight=1.
- 3 beats 0x4000,0x4040,0x4080 with last on the 3rd -> mul_ins[47:0]=0x4080_4040_4000, slots 3..7=0x3F80; perf_pads+=5 when the macro is defined.
- 16 back-to-back beats with valid held high -> two mul_stb pulses exactly 8 cycles apart; s_in_ready stays 1; a res_stb[0] pulse in the second issue cycle keeps in_flight at 1.
- 2 batches issued in mode 00, then first beat with cfg_mode=11 -> s_in_ready=0 and mode stays 00 until two res_stb[0] pulses; mode=11 the following cycle, then the beat is accepted.
- MAX_INFLIGHT=2 build, three batches with no results -> s_in_ready drops after the 2nd issue; one res_stb[0] pulse restores ready; res_stb[0] with in_flight=0 -> err_underflow=1 until rst.
- rst asserted after 5 beats -> next batch starts at slot 0; no mul_stb for the discarded partial batch.
